// File: rtl/pwm_pkg.sv
// Shared definitions for the complementary PWM generator and its receive-side decoder.
package pwm_pkg;

  localparam int          PWM_CNT_W  = 11;
  localparam logic [10:0] NONOVERLAP = 11'h040;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HI_ON,
    ST_DEAD_A,
    ST_LO_ON,
    ST_DEAD_B
  } pwm_dec_state_t;

  // Both-low and both-high are ambiguous mid-cycle, so they fall back to IDLE.
  function automatic pwm_dec_state_t state_from_levels(input logic hi, input logic lo);
    pwm_dec_state_t st;
    st = ST_IDLE;
    if (hi && !lo) st = ST_HI_ON;
    if (!hi && lo) st = ST_LO_ON;
    return st;
  endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Multi-flop synchronizer plus delay flop with registered rise/fall pulses.
// lvl is the delayed copy, so it changes in the same cycle the edge pulse is high.
module pwm_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic dly_q, dly_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    dly_d  = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~dly_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & dly_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign lvl  = dly_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/pwm_pair_decoder.sv
// Decodes a complementary PWM pair into hi/dead/lo/dead widths and period,
// flagging overlap, short dead time, out-of-order edges and loss of switching.
module pwm_pair_decoder
  import pwm_pkg::*;
#(
  parameter int               CNT_W       = PWM_CNT_W,
  parameter int               SYNC_STAGES = 2,
  parameter logic [CNT_W-1:0] MIN_DEAD    = CNT_W'(NONOVERLAP)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm_hi_in,
  input  logic             pwm_lo_in,
  input  logic             clr_fault,
  output logic [CNT_W-1:0] hi_w,
  output logic [CNT_W-1:0] dead_a_w,
  output logic [CNT_W-1:0] lo_w,
  output logic [CNT_W-1:0] dead_b_w,
  output logic [CNT_W:0]   period,
  output logic             meas_vld,
  output logic             dead_fault,
  output logic             seq_err,
  output logic             ovlp_fault,
  output logic             stale
);

  localparam logic [CNT_W-1:0] SEG_MAX = '1;
  localparam logic [CNT_W:0]   PER_MAX = '1;

  logic hi_lvl, hi_rise, hi_fall;
  logic lo_lvl, lo_rise, lo_fall;

  pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_hi (
    .clk(clk), .rst_n(rst_n), .din(pwm_hi_in), .lvl(hi_lvl), .rise(hi_rise), .fall(hi_fall)
  );
  pwm_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lo (
    .clk(clk), .rst_n(rst_n), .din(pwm_lo_in), .lvl(lo_lvl), .rise(lo_rise), .fall(lo_fall)
  );

  pwm_dec_state_t   state_q, state_d;
  logic [CNT_W-1:0] seg_cnt_q, seg_cnt_d;
  logic [CNT_W:0]   per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] cap_hi_q, cap_hi_d, cap_da_q, cap_da_d, cap_lo_q, cap_lo_d;
  logic             cyc_ok_q, cyc_ok_d;
  logic [CNT_W-1:0] hi_w_q, hi_w_d, dead_a_w_q, dead_a_w_d;
  logic [CNT_W-1:0] lo_w_q, lo_w_d, dead_b_w_q, dead_b_w_d;
  logic [CNT_W:0]   period_q, period_d;
  logic             meas_vld_q, meas_vld_d, dead_fault_q, dead_fault_d;
  logic             seq_err_q, seq_err_d, ovlp_q, ovlp_d, stale_q, stale_d;
  logic             hi_edge, lo_edge, any_edge, err, closing;

  always_comb begin
    hi_edge  = hi_rise | hi_fall;
    lo_edge  = lo_rise | lo_fall;
    any_edge = hi_edge | lo_edge;

    seg_cnt_d = any_edge ? CNT_W'(1) : ((seg_cnt_q == SEG_MAX) ? seg_cnt_q : seg_cnt_q + 1'b1);
    per_cnt_d = hi_rise ? (CNT_W+1)'(1) : ((per_cnt_q == PER_MAX) ? per_cnt_q : per_cnt_q + 1'b1);

    state_d      = state_q;
    cyc_ok_d     = cyc_ok_q;
    cap_hi_d     = cap_hi_q;
    cap_da_d     = cap_da_q;
    cap_lo_d     = cap_lo_q;
    hi_w_d       = hi_w_q;
    dead_a_w_d   = dead_a_w_q;
    lo_w_d       = lo_w_q;
    dead_b_w_d   = dead_b_w_q;
    period_d     = period_q;
    meas_vld_d   = 1'b0;
    dead_fault_d = 1'b0;
    seq_err_d    = 1'b0;
    stale_d      = stale_q;
    err          = 1'b0;
    closing      = 1'b0;

    if (state_q == ST_IDLE) begin
      if (hi_rise) begin
        state_d  = ST_HI_ON;
        cyc_ok_d = 1'b1;
      end
    end else if (any_edge) begin
      if (hi_edge && lo_edge) begin
        err = 1'b1;
      end else begin
        case (state_q)
          ST_HI_ON:  if (hi_fall) begin state_d = ST_DEAD_A; cap_hi_d = seg_cnt_q; end else err = 1'b1;
          ST_DEAD_A: if (lo_rise) begin state_d = ST_LO_ON;  cap_da_d = seg_cnt_q; end else err = 1'b1;
          ST_LO_ON:  if (lo_fall) begin state_d = ST_DEAD_B; cap_lo_d = seg_cnt_q; end else err = 1'b1;
          ST_DEAD_B: if (hi_rise) begin
                       state_d  = ST_HI_ON;
                       closing  = cyc_ok_q;
                       cyc_ok_d = 1'b1;
                     end else err = 1'b1;
          default:   err = 1'b1;
        endcase
      end
    end else if (seg_cnt_q == SEG_MAX) begin
      state_d = ST_IDLE;
      stale_d = 1'b1;
    end

    // A resync mid-cycle leaves earlier captures untrustworthy until the next legal hi rise.
    if (err) begin
      seq_err_d = 1'b1;
      state_d   = state_from_levels(hi_lvl, lo_lvl);
      cyc_ok_d  = 1'b0;
    end

    if (closing) begin
      hi_w_d       = cap_hi_q;
      dead_a_w_d   = cap_da_q;
      lo_w_d       = cap_lo_q;
      dead_b_w_d   = seg_cnt_q;
      period_d     = per_cnt_q;
      meas_vld_d   = 1'b1;
      stale_d      = 1'b0;
      dead_fault_d = (cap_da_q < MIN_DEAD) || (seg_cnt_q < MIN_DEAD);
    end

    ovlp_d = (hi_lvl & lo_lvl) | (ovlp_q & ~clr_fault);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      seg_cnt_q    <= '0;
      per_cnt_q    <= '0;
      cap_hi_q     <= '0;
      cap_da_q     <= '0;
      cap_lo_q     <= '0;
      cyc_ok_q     <= 1'b0;
      hi_w_q       <= '0;
      dead_a_w_q   <= '0;
      lo_w_q       <= '0;
      dead_b_w_q   <= '0;
      period_q     <= '0;
      meas_vld_q   <= 1'b0;
      dead_fault_q <= 1'b0;
      seq_err_q    <= 1'b0;
      ovlp_q       <= 1'b0;
      stale_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      seg_cnt_q    <= seg_cnt_d;
      per_cnt_q    <= per_cnt_d;
      cap_hi_q     <= cap_hi_d;
      cap_da_q     <= cap_da_d;
      cap_lo_q     <= cap_lo_d;
      cyc_ok_q     <= cyc_ok_d;
      hi_w_q       <= hi_w_d;
      dead_a_w_q   <= dead_a_w_d;
      lo_w_q       <= lo_w_d;
      dead_b_w_q   <= dead_b_w_d;
      period_q     <= period_d;
      meas_vld_q   <= meas_vld_d;
      dead_fault_q <= dead_fault_d;
      seq_err_q    <= seq_err_d;
      ovlp_q       <= ovlp_d;
      stale_q      <= stale_d;
    end
  end

  assign hi_w       = hi_w_q;
  assign dead_a_w   = dead_a_w_q;
  assign lo_w       = lo_w_q;
  assign dead_b_w   = dead_b_w_q;
  assign period     = period_q;
  assign meas_vld   = meas_vld_q;
  assign dead_fault = dead_fault_q;
  assign seq_err    = seq_err_q;
  assign ovlp_fault = ovlp_q;
  assign stale      = stale_q;

endmodule

// File: tb/tb_pwm_pair_decoder.sv
// Directed bench for pwm_pair_decoder: pattern table plus hand-written corner sequences.
module tb_pwm_pair_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pwm_hi_in = 1'b0;
  logic        pwm_lo_in = 1'b0;
  logic        clr_fault = 1'b0;
  logic [10:0] hi_w, dead_a_w, lo_w, dead_b_w;
  logic [11:0] period;
  logic        meas_vld, dead_fault, seq_err, ovlp_fault, stale;

  always #5 clk = ~clk;

  pwm_pair_decoder dut (
    .clk(clk), .rst_n(rst_n), .pwm_hi_in(pwm_hi_in), .pwm_lo_in(pwm_lo_in),
    .clr_fault(clr_fault), .hi_w(hi_w), .dead_a_w(dead_a_w), .lo_w(lo_w),
    .dead_b_w(dead_b_w), .period(period), .meas_vld(meas_vld),
    .dead_fault(dead_fault), .seq_err(seq_err), .ovlp_fault(ovlp_fault), .stale(stale)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Event monitor, sampled just after each rising edge.
  int   cyc = 0, n_meas = 0, n_seq = 0, n_stray_df = 0, t_meas = 0, t_prev = 0;
  logic last_df = 1'b0;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (meas_vld) begin
      n_meas++;
      t_prev  = t_meas;
      t_meas  = cyc;
      last_df = dead_fault;
    end
    if (seq_err) n_seq++;
    if (dead_fault && !meas_vld) n_stray_df++;
  end

  task automatic seg(input logic hi, input logic lo, input int n);
    pwm_hi_in = hi;
    pwm_lo_in = lo;
    repeat (n) @(negedge clk);
  endtask

  task automatic cyc4(input int h, input int da, input int l, input int db);
    seg(1'b1, 1'b0, h);
    seg(1'b0, 1'b0, da);
    seg(1'b0, 1'b1, l);
    seg(1'b0, 1'b0, db);
  endtask

  typedef struct {
    int   h, da, l, db;
    int   exp_per;
    int   exp_int;
    int   exp_nm;
    logic exp_df;
  } vec_t;

  vec_t vt[5];

  initial begin
    int m0, s0;

    vt[0] = '{1000,   64,  920,   64, 2048, 2048, 2, 1'b0};
    vt[1] = '{1000,   10,  920,   64, 1994, 1994, 3, 1'b1};
    vt[2] = '{ 500,   64,  400,   63, 1027, 1027, 3, 1'b1};
    vt[3] = '{1200,  100, 1200,  100, 2600, 2600, 3, 1'b0};
    vt[4] = '{1100, 1100, 1100, 1100, 4095, 4400, 3, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_hi_w", hi_w, 0);
    chk("rst_dead_a_w", dead_a_w, 0);
    chk("rst_lo_w", lo_w, 0);
    chk("rst_dead_b_w", dead_b_w, 0);
    chk("rst_period", period, 0);
    chk("rst_meas_vld", meas_vld, 0);
    chk("rst_dead_fault", dead_fault, 0);
    chk("rst_seq_err", seq_err, 0);
    chk("rst_ovlp", ovlp_fault, 0);
    chk("rst_stale", stale, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      m0 = n_meas;
      repeat (3) cyc4(vt[i].h, vt[i].da, vt[i].l, vt[i].db);
      chk($sformatf("v%0d_hi_w", i), hi_w, vt[i].h);
      chk($sformatf("v%0d_dead_a_w", i), dead_a_w, vt[i].da);
      chk($sformatf("v%0d_lo_w", i), lo_w, vt[i].l);
      chk($sformatf("v%0d_dead_b_w", i), dead_b_w, vt[i].db);
      chk($sformatf("v%0d_period", i), period, vt[i].exp_per);
      chk($sformatf("v%0d_dead_fault", i), last_df, vt[i].exp_df);
      chk($sformatf("v%0d_meas_interval", i), t_meas - t_prev, vt[i].exp_int);
      chk($sformatf("v%0d_meas_count", i), n_meas - m0, vt[i].exp_nm);
      chk($sformatf("v%0d_stale", i), stale, 0);
    end
    chk("vec_seq_err_count", n_seq, 0);
    chk("vec_ovlp", ovlp_fault, 0);
    chk("vec_stray_dead_fault", n_stray_df, 0);

    // Overlap: set, clear while legal, clear attempt during overlap.
    s0 = n_seq;
    seg(1'b1, 1'b1, 3);
    seg(1'b0, 1'b0, 10);
    chk("ovlp_set", ovlp_fault, 1);
    chk("ovlp_simul_edge_seq_err", n_seq - s0, 1);
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    @(negedge clk);
    chk("ovlp_cleared", ovlp_fault, 0);
    seg(1'b1, 1'b1, 5);
    clr_fault = 1'b1;
    repeat (2) @(negedge clk);
    clr_fault = 1'b0;
    @(negedge clk);
    chk("ovlp_set_wins", ovlp_fault, 1);
    seg(1'b0, 1'b0, 10);
    chk("ovlp_sticky", ovlp_fault, 1);
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    @(negedge clk);
    chk("ovlp_cleared2", ovlp_fault, 0);

    // Timeout: nominal, then both low long enough to saturate the segment counter.
    m0 = n_meas;
    repeat (2) cyc4(1000, 64, 920, 64);
    chk("to_meas_count", n_meas - m0, 1);
    chk("to_stale_before", stale, 0);
    s0 = n_seq;
    seg(1'b0, 1'b0, 1900);
    chk("to_stale_not_yet", stale, 0);
    seg(1'b0, 1'b0, 1100);
    chk("to_stale_set", stale, 1);
    chk("to_no_seq_err", n_seq - s0, 0);
    m0 = n_meas;
    cyc4(1000, 64, 920, 64);
    chk("to_resume_stale_held", stale, 1);
    chk("to_resume_no_meas", n_meas - m0, 0);
    cyc4(1000, 64, 920, 64);
    chk("to_resume_stale_clr", stale, 0);
    chk("to_resume_meas", n_meas - m0, 1);
    chk("to_resume_hi_w", hi_w, 1000);
    chk("to_resume_period", period, 2048);

    // Reset in the middle of LO_ON.
    seg(1'b1, 1'b0, 1000);
    seg(1'b0, 1'b0, 64);
    seg(1'b0, 1'b1, 400);
    rst_n = 1'b0;
    #1;
    chk("mrst_hi_w", hi_w, 0);
    chk("mrst_lo_w", lo_w, 0);
    chk("mrst_period", period, 0);
    chk("mrst_meas_vld", meas_vld, 0);
    chk("mrst_stale", stale, 1);
    chk("mrst_ovlp", ovlp_fault, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seg(1'b0, 1'b1, 500);
    seg(1'b0, 1'b0, 64);

    // Duty 0 after one hi pulse: every later lo rise lands in DEAD_B.
    m0 = n_meas;
    s0 = n_seq;
    seg(1'b1, 1'b0, 1000);
    seg(1'b0, 1'b0, 64);
    repeat (3) begin
      seg(1'b0, 1'b1, 1984);
      seg(1'b0, 1'b0, 64);
    end
    chk("d0_seq_err_count", n_seq - s0, 2);
    chk("d0_no_meas", n_meas - m0, 0);
    chk("d0_stale", stale, 1);
    seg(1'b0, 1'b0, 2200);
    seg(1'b0, 1'b1, 100);
    seg(1'b0, 1'b0, 100);
    chk("d0_idle_ignores_lo", n_seq - s0, 2);
    chk("d0_stale_after_to", stale, 1);
    repeat (2) cyc4(1000, 64, 920, 64);
    chk("d0_first_meas", n_meas - m0, 1);
    chk("d0_lo_w", lo_w, 920);
    chk("d0_dead_a_w", dead_a_w, 64);
    chk("d0_dead_b_w", dead_b_w, 64);
    chk("d0_stale_clr", stale, 0);
    chk("end_stray_dead_fault", n_stray_df, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pwm_pair_decoder.md
Name: pwm_pair_decoder

Overview:
Receive-side counterpart to the 11-bit complementary PWM generator. Takes a complementary pair (high-side/low-side gate signals) from a pin or a loopback path and synchronizes both inputs. Measures each segment of the switching cycle (high-side on, dead A, low-side on, dead B) and the full period. Flags shoot-through overlap, insufficient dead time, out-of-sequence edges and loss of switching. Used for gate-drive loopback checking and for decoding PWM-coded sensor inputs.

Parameters:
CNT_W, 11, segment counter width; period counter is CNT_W+1 bits
SYNC_STAGES, 2, flops in each input synchronizer (min 2)
MIN_DEAD, 11'd64, minimum legal dead time in clocks (matches generator NONOVERLAP)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pwm_hi_in  in  1  high-side PWM, asynchronous
pwm_lo_in  in  1  low-side PWM, asynchronous
clr_fault  in  1  synchronous clear of sticky ovlp_fault
hi_w  out  CNT_W  high-side on width, clocks
dead_a_w  out  CNT_W  hi fall to lo rise, clocks
lo_w  out  CNT_W  low-side on width, clocks
dead_b_w  out  CNT_W  lo fall to hi rise, clocks
period  out  CNT_W+1  hi rise to next hi rise, clocks
meas_vld  out  1  one-cycle pulse; all width outputs updated together
dead_fault  out  1  one-cycle pulse with meas_vld when dead_a_w or dead_b_w < MIN_DEAD
seq_err  out  1  one-cycle pulse on out-of-order edge
ovlp_fault  out  1  sticky; both synced inputs high in same cycle
stale  out  1  level; no complete cycle since reset or timeout

Behaviour:
- Reset: all width and period outputs 0; meas_vld, dead_fault, seq_err and ovlp_fault 0; stale 1; FSM in IDLE; synchronizers 0.
- Each input passes through SYNC_STAGES flops plus one delay flop. A rise or fall is detected in the cycle where the synced value differs from the delayed copy. Synchronizer latency is equal on both inputs, so widths are exact.
- seg_cnt (CNT_W bits):
  - loads 1 on the clock after any detected transition-causing edge, else increments;
  - saturates at all-ones;
  - a captured width equals the clocks between the two detecting edges.
- per_cnt (CNT_W+1 bits): same rule, restarted only by a hi rise; saturates.
- FSM states: IDLE, HI_ON, DEAD_A, LO_ON, DEAD_B.
  - IDLE: hi rise -> HI_ON (start per_cnt); all other edges ignored.
  - HI_ON: hi fall -> DEAD_A, capture hi width.
  - DEAD_A: lo rise -> LO_ON, capture dead A.
  - LO_ON: lo fall -> DEAD_B, capture lo width.
  - DEAD_B: hi rise -> HI_ON. Register all five values to outputs, pulse meas_vld, clear stale, restart counters.
  - Any other edge in a non-IDLE state -> pulse seq_err; go to the state implied by the current synced levels; discard the partial cycle (no meas_vld until a full sequence completes). Example: duty-0 input with lo toggling and hi never high (DEAD_B + lo rise -> LO_ON, seq_err).
- meas_vld timing: asserted for one cycle, starting SYNC_STAGES+1 clocks after the clock edge that first samples the closing hi rise. Outputs hold until the next meas_vld.
- Timeout: if seg_cnt saturates in any non-IDLE state -> stale=1, FSM -> IDLE, no seq_err.
- ovlp_fault:
  - sets in any cycle where both synced inputs are 1, in any state including IDLE;
  - clr_fault clears it, but set wins if both occur in the same cycle;
  - overlap does not by itself change FSM state.
- Simultaneous hi and lo edges in one cycle: treat as seq_err; resync to levels.
- Period overflow: period saturates at 2^(CNT_W+1)-1; stale is unaffected.

Decomposition:
- Shared package pwm_pkg: FSM state enum (pwm_dec_state_t), NONOVERLAP = 11'h040 (shared with the generator), default CNT_W.
- Sub-module pwm_sync_edge: SYNC_STAGES synchronizer, delay flop, rise/fall pulses and synced level. Instantiated once per input.
- Expected RTL: roughly 200-250 lines total.

Test Plan:
- Nominal: hi 1000 clk, low 64, lo 920, low 64, repeated -> from the 2nd cycle on, meas_vld each 2048 clk; hi_w=1000, dead_a_w=64, lo_w=920, dead_b_w=64, period=2048; no faults.
- Short dead time: dead A = 10 clk, other segments nominal -> dead_a_w=10, dead_fault pulses with meas_vld.
- Overlap: both inputs high for 3 clk -> ovlp_fault=1 and held; clr_fault pulse while inputs are legal -> 0; clr_fault during overlap -> stays 1.
- Duty 0: hi held 0, lo 1984 high / 64 low -> seq_err per cycle, no meas_vld, stale stays 1; after 2048 clk with no edge -> stale=1, FSM IDLE.
- Timeout: nominal pattern, then both inputs held low 3000 clk -> stale=1 at seg_cnt saturation; resume nominal -> stale=0 at next meas_vld.
- Reset mid-LO_ON: assert rst_n low -> all outputs at reset values; after release, no meas_vld until a full hi->hi cycle completes.
